// File: rtl/pipe_trace_buffer.sv
// Instruction-trace capture: classifies one pipeline stage's PC/instruction per cycle into a timestamped circular buffer.
// Latency: a sample at edge N is visible in status/counters after edge N; rd_data/rd_valid register one edge after rd_en.
// Backpressure: none toward the pipeline; when full it either freezes (wrap_mode=0) or overwrites the oldest entry (wrap_mode=1).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       capture control pulses (start wins when both are high)
//   trig_en, trig_pc  arm on start and wait for trig_pc before recording
//   wrap_mode         1 = overwrite oldest when full, 0 = freeze when full
//   stall, bubble     sampled-stage qualifiers; stalled cycles are not recorded
//   pc, instr         sampled-stage PC and instruction word
//   rd_en             pop one entry; rd_data = {timestamp, pc, class}, rd_valid pulses per pop
//   empty, full       buffer status; overflow is sticky after an overwrite
//   state             0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN
//   *_cnt             saturating performance counters
module pipe_trace_buffer #(
    parameter int PC_W  = 32,
    parameter int TS_W  = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   trig_en,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic                   wrap_mode,
    input  logic                   stall,
    input  logic                   bubble,
    input  logic [PC_W-1:0]        pc,
    input  logic [31:0]            instr,
    input  logic                   rd_en,
    output logic [TS_W+PC_W+4:0]   rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       retired_cnt,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       nop_cnt
);

    localparam int EW = TS_W + PC_W + 5;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [4:0] CLS_NOP     = 5'd0;
    localparam logic [4:0] CLS_BUBBLE  = 5'd1;
    localparam logic [4:0] CLS_UNKNOWN = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } state_t;

    state_t          st;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;

    logic            trig_hit;
    logic            cap_cycle;
    logic            wr_req;
    logic            pop;
    logic            do_write;
    logic            overwrite;
    logic            freeze;
    logic [4:0]      cls;
    logic [EW-1:0]   wr_entry;

    function automatic logic [4:0] classify(input logic bub, input logic [31:0] w);
        logic [4:0] c;
        c = CLS_UNKNOWN;
        if (bub) begin
            c = CLS_BUBBLE;
        end else if (w == 32'd0) begin
            c = CLS_NOP;
        end else begin
            case (w[31:26])
                6'd0: begin
                    case (w[5:0])
                        6'd32:   c = 5'd2;   // ADD
                        6'd34:   c = 5'd3;   // SUB
                        6'd36:   c = 5'd4;   // AND
                        6'd37:   c = 5'd5;   // OR
                        6'd42:   c = 5'd6;   // SLT
                        6'd25:   c = 5'd7;   // MULTU
                        6'd16:   c = 5'd8;   // MFHI
                        6'd18:   c = 5'd9;   // MFLO
                        6'd0:    c = 5'd10;  // SLL (non-zero word, so not a NOP)
                        default: c = CLS_UNKNOWN;
                    endcase
                end
                6'd35:   c = 5'd11;  // LW
                6'd43:   c = 5'd12;  // SW
                6'd4:    c = 5'd13;  // BEQ
                6'd3:    c = 5'd14;  // JAL
                6'd2:    c = 5'd15;  // J
                6'd9:    c = 5'd16;  // ADDIU
                default: c = CLS_UNKNOWN;
            endcase
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign state = st;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_comb begin
        // The trigger-match cycle behaves exactly like the first CAPTURE cycle.
        trig_hit  = (st == ARMED) && !stall && (pc == trig_pc);
        cap_cycle = !start && !stop && ((st == CAPTURE) || trig_hit);
        wr_req    = cap_cycle && !stall;
        // A start cycle clears the buffer, so any read on it is dropped.
        pop       = rd_en && !empty && !start;
        do_write  = wr_req && (!full || pop || wrap_mode);
        overwrite = do_write && !pop && full;
        cls       = classify(bubble, instr);
        wr_entry  = {cycle_cnt[TS_W-1:0], pc, cls};

        count_next = count;
        if (do_write && !pop && !overwrite) begin
            count_next = count + (AW+1)'(1);
        end else if (!do_write && pop) begin
            count_next = count - (AW+1)'(1);
        end

        freeze = do_write && !wrap_mode && (count_next == FULL_CNT);
    end

    // Storage has no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            bubble_cnt  <= '0;
            nop_cnt     <= '0;
        end else if (start) begin
            st          <= trig_en ? ARMED : CAPTURE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            rd_valid    <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            bubble_cnt  <= '0;
            nop_cnt     <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
            end

            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // An overwrite discards the oldest entry, so the read side skips it.
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (overwrite) begin
                overflow <= 1'b1;
            end
            count <= count_next;

            if (cap_cycle) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if (do_write) begin
                if (cls == CLS_BUBBLE) begin
                    bubble_cnt <= sat_inc(bubble_cnt);
                end else if (cls == CLS_NOP) begin
                    nop_cnt <= sat_inc(nop_cnt);
                end else begin
                    retired_cnt <= sat_inc(retired_cnt);
                end
            end

            case (st)
                IDLE:    st <= IDLE;
                ARMED: begin
                    if (stop)          st <= IDLE;
                    else if (trig_hit) st <= freeze ? FROZEN : CAPTURE;
                end
                CAPTURE: begin
                    if (stop)        st <= IDLE;
                    else if (freeze) st <= FROZEN;
                end
                FROZEN: begin
                    if (stop) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
module tb_pipe_trace_buffer;

    localparam int PC_W  = 32;
    localparam int TS_W  = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int EW    = TS_W + PC_W + 5;

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8C010000;
    localparam logic [31:0] I_SLL = 32'h00011040;
    localparam logic [31:0] I_J   = 32'h08000000;
    localparam logic [31:0] I_UNK = 32'hFC000000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              trig_en;
    logic [PC_W-1:0]   trig_pc;
    logic              wrap_mode;
    logic              stall;
    logic              bubble;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic              rd_en;
    logic [EW-1:0]     rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              overflow;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  nop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [EW-1:0] exp_q [$];

    pipe_trace_buffer #(
        .PC_W (PC_W),
        .TS_W (TS_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .wrap_mode  (wrap_mode),
        .stall      (stall),
        .bubble     (bubble),
        .pc         (pc),
        .instr      (instr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt),
        .bubble_cnt (bubble_cnt),
        .nop_cnt    (nop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic te, input logic [31:0] tpc, input logic wm);
        start = 1'b1; trig_en = te; trig_pc = tpc; wrap_mode = wm;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    // Drive one pipeline sample; rec/ts/cls describe the entry expected in the buffer.
    // When rd is set, the popped entry is checked against the scoreboard front.
    task automatic tick(input logic [31:0] p, input logic [31:0] ins, input logic bub,
                        input logic stl, input logic rec, input int ts,
                        input logic [4:0] cls, input logic rd);
        logic [EW-1:0] exp_rd;
        logic          have_exp;
        have_exp = (exp_q.size() > 0);
        exp_rd   = have_exp ? exp_q[0] : '0;
        pc = p; instr = ins; bubble = bub; stall = stl; rd_en = rd;
        if (rec) exp_q.push_back({16'(ts), p, cls});
        cycle();
        if (rd) begin
            total_cnt++;
            if (!have_exp || rd_valid !== 1'b1 || rd_data !== exp_rd)
                $display("FAIL tick_read: rd_valid=%0b rd_data=%h required %h", rd_valid, rd_data, exp_rd);
            else
                pass_cnt++;
            if (have_exp) void'(exp_q.pop_front());
        end
        rd_en = 1'b0; stall = 1'b0; bubble = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [EW-1:0] exp_rd;
            logic          have_exp;
            have_exp = (exp_q.size() > 0);
            exp_rd   = have_exp ? exp_q.pop_front() : '0;
            rd_en = 1'b1;
            cycle();
            total_cnt++;
            if (!have_exp || rd_valid !== 1'b1 || rd_data !== exp_rd)
                $display("FAIL %s_read%0d: rd_valid=%0b rd_data=%h required %h", tag, i, rd_valid, rd_data, exp_rd);
            else
                pass_cnt++;
        end
        rd_en = 1'b0;
        cycle();
        total_cnt++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL %s_empty: empty=%0b rd_valid=%0b left=%0d required empty=1 rd_valid=0 left=0", tag, empty, rd_valid, exp_q.size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total_cnt++;
        if (state !== 2'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== '0)
            $display("FAIL reset_status: state=%0d empty=%0b full=%0b ovf=%0b rdv=%0b rdd=%h required 0 1 0 0 0 0",
                     state, empty, full, overflow, rd_valid, rd_data);
        else
            pass_cnt++;
        total_cnt++;
        if (cycle_cnt !== '0 || retired_cnt !== '0 || bubble_cnt !== '0 || nop_cnt !== '0)
            $display("FAIL reset_counters: cyc=%0d ret=%0d bub=%0d nop=%0d required all 0",
                     cycle_cnt, retired_cnt, bubble_cnt, nop_cnt);
        else
            pass_cnt++;
    endtask

    task automatic test_basic();
        do_start(1'b0, 32'h0, 1'b0);
        total_cnt++;
        if (state !== 2'd2) $display("FAIL basic_state: state=%0d required 2", state);
        else pass_cnt++;
        tick(32'h0, I_ADD, 1'b0, 1'b0, 1'b1, 0, 5'd2, 1'b0);
        total_cnt++;
        if (empty !== 1'b0) $display("FAIL basic_not_empty: empty=%0b required 0", empty);
        else pass_cnt++;
        tick(32'h4, I_ADD, 1'b0, 1'b0, 1'b1, 1, 5'd2, 1'b0);
        tick(32'h8, I_ADD, 1'b0, 1'b0, 1'b1, 2, 5'd2, 1'b0);
        do_stop();
        total_cnt++;
        if (state !== 2'd0 || retired_cnt !== 32'd3 || cycle_cnt !== 32'd3)
            $display("FAIL basic_counters: state=%0d ret=%0d cyc=%0d required 0 3 3", state, retired_cnt, cycle_cnt);
        else
            pass_cnt++;
        drain(3, "basic");
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; trig_en = 1'b0; wrap_mode = 1'b0;
        cycle();
        start = 1'b0; stop = 1'b0;
        total_cnt++;
        if (state !== 2'd2) $display("FAIL start_wins: state=%0d required 2", state);
        else pass_cnt++;
        do_stop();
    endtask

    task automatic test_trigger();
        do_start(1'b1, 32'h10, 1'b0);
        total_cnt++;
        if (state !== 2'd1) $display("FAIL trig_armed: state=%0d required 1", state);
        else pass_cnt++;
        for (int i = 0; i < 4; i++)
            tick(32'(i * 4), I_ADD, 1'b0, 1'b0, 1'b0, 0, 5'd2, 1'b0);
        total_cnt++;
        if (state !== 2'd1 || empty !== 1'b1 || cycle_cnt !== '0)
            $display("FAIL trig_wait: state=%0d empty=%0b cyc=%0d required 1 1 0", state, empty, cycle_cnt);
        else
            pass_cnt++;
        for (int i = 4; i < 8; i++) begin
            tick(32'(i * 4), I_ADD, 1'b0, 1'b0, 1'b1, i - 4, 5'd2, 1'b0);
            if (i == 4) begin
                total_cnt++;
                if (state !== 2'd2) $display("FAIL trig_hit: state=%0d required 2", state);
                else pass_cnt++;
            end
        end
        do_stop();
        total_cnt++;
        if (retired_cnt !== 32'd4) $display("FAIL trig_count: ret=%0d required 4", retired_cnt);
        else pass_cnt++;
        drain(4, "trig");
    endtask

    task automatic test_freeze();
        do_start(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(32'(i * 4), I_ADD, 1'b0, 1'b0, (i < DEPTH), i, 5'd2, 1'b0);
            if (i == DEPTH - 1) begin
                total_cnt++;
                if (state !== 2'd3 || full !== 1'b1 || overflow !== 1'b0 || cycle_cnt !== 32'd16)
                    $display("FAIL freeze_at16: state=%0d full=%0b ovf=%0b cyc=%0d required 3 1 0 16",
                             state, full, overflow, cycle_cnt);
                else
                    pass_cnt++;
            end
        end
        total_cnt++;
        if (state !== 2'd3 || cycle_cnt !== 32'd16 || retired_cnt !== 32'd16)
            $display("FAIL freeze_hold: state=%0d cyc=%0d ret=%0d required 3 16 16", state, cycle_cnt, retired_cnt);
        else
            pass_cnt++;
        drain(DEPTH, "freeze");
        do_stop();
    endtask

    task automatic test_wrap();
        do_start(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++)
            tick(32'(32'h200 + i * 4), I_ADD, 1'b0, 1'b0, 1'b1, i, 5'd2, 1'b0);
        // The first four entries were overwritten.
        for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
        total_cnt++;
        if (state !== 2'd2 || full !== 1'b1 || overflow !== 1'b1)
            $display("FAIL wrap_status: state=%0d full=%0b ovf=%0b required 2 1 1", state, full, overflow);
        else
            pass_cnt++;
        // Simultaneous read and write while full: oldest (timestamp 4) comes out.
        tick(32'h500, I_ADD, 1'b0, 1'b0, 1'b1, 20, 5'd2, 1'b1);
        total_cnt++;
        if (full !== 1'b1 || overflow !== 1'b1)
            $display("FAIL wrap_rw_full: full=%0b ovf=%0b required 1 1", full, overflow);
        else
            pass_cnt++;
        do_stop();
        drain(DEPTH, "wrap");
    endtask

    task automatic test_mix();
        do_start(1'b0, 32'h0, 1'b0);
        tick(32'h100, I_ADD, 1'b0, 1'b0, 1'b1, 0, 5'd2,  1'b0);
        tick(32'h104, I_ADD, 1'b1, 1'b0, 1'b1, 1, 5'd1,  1'b0);
        tick(32'h108, I_ADD, 1'b0, 1'b1, 1'b0, 2, 5'd2,  1'b0);
        tick(32'h108, 32'h0, 1'b0, 1'b0, 1'b1, 3, 5'd0,  1'b0);
        tick(32'h10C, I_UNK, 1'b0, 1'b0, 1'b1, 4, 5'd31, 1'b0);
        tick(32'h110, 32'h0, 1'b1, 1'b0, 1'b1, 5, 5'd1,  1'b0);
        tick(32'h110, I_LW,  1'b1, 1'b1, 1'b0, 6, 5'd1,  1'b0);
        tick(32'h110, I_LW,  1'b0, 1'b0, 1'b1, 7, 5'd11, 1'b0);
        tick(32'h114, I_SLL, 1'b0, 1'b0, 1'b1, 8, 5'd10, 1'b0);
        tick(32'h118, I_J,   1'b0, 1'b0, 1'b1, 9, 5'd15, 1'b0);
        total_cnt++;
        if (bubble_cnt !== 32'd2 || nop_cnt !== 32'd1 || retired_cnt !== 32'd5 || cycle_cnt !== 32'd10)
            $display("FAIL mix_counters: bub=%0d nop=%0d ret=%0d cyc=%0d required 2 1 5 10",
                     bubble_cnt, nop_cnt, retired_cnt, cycle_cnt);
        else
            pass_cnt++;
        do_stop();
        drain(8, "mix");
    endtask

    task automatic test_reset_mid();
        do_start(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            tick(32'(i * 4), I_ADD, 1'b0, 1'b0, 1'b1, i, 5'd2, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        total_cnt++;
        if (state !== 2'd0 || empty !== 1'b1 || cycle_cnt !== '0 || retired_cnt !== '0)
            $display("FAIL rst_mid: state=%0d empty=%0b cyc=%0d ret=%0d required 0 1 0 0",
                     state, empty, cycle_cnt, retired_cnt);
        else
            pass_cnt++;
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL rd_on_empty: rd_valid=%0b required 0", rd_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
        wrap_mode = 1'b0; stall = 1'b0; bubble = 1'b0; pc = '0; instr = '0; rd_en = 1'b0;
        test_reset();
        test_basic();
        test_start_stop();
        test_trigger();
        test_freeze();
        test_wrap();
        test_mix();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
